proc_core: RTL and testbench
============================

PROC_CORE -- requirements
Module: proc_core

Interface
REQ-001 SHALL have port f_clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port start_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port start_addr, input, 8 bits: PC value loaded while start_n is low.
REQ-004 SHALL have port instr_i, input, 8 bits: instruction at pc_o, from external ROM, combinational.
REQ-005 SHALL have ports rs1_data_i and rs2_data_i, input, 8 bits each: register-file read data for rs1_o and rs2_o.
REQ-006 SHALL have port cond_i, input, 1 bit: stored condition bit from the register file.
REQ-007 SHALL have port pc_o, output, 8 bits: registered program counter.
REQ-008 SHALL have ports mem_read_o, mem_write_o, label_read_o, label_write_o, reg_write_o, halt_o; output, 1 bit each: decoded controls.
REQ-009 SHALL have port alu_op_o, output, 4 bits, equal to instr_i[7:4].
REQ-010 SHALL have port branch_addr_o, output, 4 bits, equal to instr_i[3:0].
REQ-011 SHALL have port const_o, output, 2 bits, equal to instr_i[1:0].
REQ-012 SHALL have ports rd_o, rs1_o, rs2_o, output, 3 bits each: rd_o = rs1_o = {0,instr_i[3:2]}; rs2_o = {0,instr_i[1:0]}.
REQ-013 SHALL have port alu_out_o, output, 8 bits: ALU result, also used as branch target.
REQ-014 SHALL have port overflow_o, output, 1 bit: carry/borrow flag.
REQ-015 SHALL have port taken_o, output, 1 bit: branch taken this cycle.
REQ-016 SHALL have port halted_o, output, 1 bit: registered halt status.

Function
REQ-017 Decode and ALU SHALL be purely combinational from instr_i, rs1_data_i, rs2_data_i and cond_i.
REQ-018 Operands: A = rs1_data_i, B = rs2_data_i, k = const_o + 1.
REQ-019 Opcode 0x0 ADD: A+B mod 256; overflow = carry-out.
REQ-020 Opcode 0x1 SUB: A-B mod 256; overflow = borrow (A<B).
REQ-021 Opcodes 0x2 AND, 0x3 OR, 0x4 XOR: bitwise result; overflow 0.
REQ-022 Opcode 0x5 SHL: A<<k; overflow = OR of bits shifted out.
REQ-023 Opcode 0x6 SHR: logical A>>k; overflow 0.
REQ-024 Opcode 0x7 ADDI: A+const_o; overflow = carry-out.
REQ-025 Opcodes 0x0-0x7 and 0xA SHALL assert reg_write_o.
REQ-026 Opcode 0x8 LD: mem_read_o=1, reg_write_o=1; address B; alu_out_o = B.
REQ-027 Opcode 0x9 ST: mem_write_o=1; address B, data A; alu_out_o = B.
REQ-028 Opcode 0xA SLT: result 1 if A<B unsigned, else 0; overflow 0.
REQ-029 Opcode 0xB BR: label_read_o=1; alu_out_o = A (label value); taken_o=1.
REQ-030 Opcode 0xC BC: label_read_o=1; alu_out_o = A; taken_o = cond_i.
REQ-031 Opcode 0xD LBL: label_write_o=1, reg_write_o=1; alu_out_o = 0.
REQ-032 Opcode 0xE NOP: all controls 0; alu_out_o = 0.
REQ-033 Opcode 0xF HALT: halt_o=1; alu_out_o = 0.
REQ-034 Controls not listed for an opcode SHALL be 0; overflow_o SHALL be 0 for opcodes 0x8-0xF.
REQ-035 PC update each edge, by priority: halted_o or halt_o holds the PC; else taken_o loads alu_out_o; else PC+1 with 0xFF wrapping to 0x00.
REQ-036 halted_o SHALL set on the edge where halt_o=1 and stay set until reset; while set, pc_o is frozen.

Reset
REQ-037 While start_n=0: pc_o = start_addr (asynchronous, continuously tracking start_addr); halted_o = 0.
REQ-038 On release of start_n, the first fetch SHALL be at start_addr, with no skipped or repeated instruction.
REQ-039 Reset asserted mid-operation, including while halted, SHALL immediately restore the state in REQ-037.

Structure
REQ-040 A package proc_pkg SHALL hold the 4-bit opcode enum and the widths (DATA_W=8, PC_W=8, REG_W=3, LBL_W=4).
REQ-041 The ALU SHALL be one sub-module, proc_alu; decode and PC logic SHALL live in proc_core.

Verification
REQ-042 start_addr=0x10, reset, release, NOP stream -> pc_o 0x10, 0x11, 0x12 on successive edges.
REQ-043 ADD with A=0xF0, B=0x20 -> alu_out_o=0x10, overflow_o=1, reg_write_o=1; SUB with A=0x05, B=0x07 -> 0xFE, overflow_o=1.
REQ-044 BR with A=0x40 at PC 0x05 -> taken_o=1, next pc_o=0x40; BC with cond_i=0 -> next pc_o=0x06.
REQ-045 HALT at PC 0x07 -> halted_o=1 after the edge, pc_o stays 0x07 for 10 cycles; start_n low -> pc_o=start_addr, halted_o=0.
REQ-046 PC at 0xFF with NOP -> next pc_o=0x00; SHL with A=0x81, const 0 -> 0x02, overflow_o=1.
REQ-047 LD/ST/LBL -> exactly mem_read_o, mem_write_o and label_write_o+reg_write_o asserted, respectively.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared types and widths for the 8-bit processor core.
package proc_pkg;

    localparam int DATA_W = 8;
    localparam int PC_W   = 8;
    localparam int REG_W  = 3;
    localparam int LBL_W  = 4;
    localparam int OP_W   = 4;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_XOR  = 4'h4,
        OP_SHL  = 4'h5,
        OP_SHR  = 4'h6,
        OP_ADDI = 4'h7,
        OP_LD   = 4'h8,
        OP_ST   = 4'h9,
        OP_SLT  = 4'hA,
        OP_BR   = 4'hB,
        OP_BC   = 4'hC,
        OP_LBL  = 4'hD,
        OP_NOP  = 4'hE,
        OP_HALT = 4'hF
    } opcode_t;

    // Decoded control bundle, one bit per external control output.
    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic label_read;
        logic label_write;
        logic reg_write;
        logic halt;
    } ctrl_t;

endpackage

// File: rtl/proc_if.sv
// Fetch / register-file / control bus between the core and its environment.
// master = core side, slave = ROM + register file + memory side.
interface proc_if;
    import proc_pkg::*;

    logic [DATA_W-1:0] instr_i;
    logic [DATA_W-1:0] rs1_data_i;
    logic [DATA_W-1:0] rs2_data_i;
    logic              cond_i;

    logic [PC_W-1:0]   pc_o;
    logic              mem_read_o;
    logic              mem_write_o;
    logic              label_read_o;
    logic              label_write_o;
    logic              reg_write_o;
    logic              halt_o;
    logic [OP_W-1:0]   alu_op_o;
    logic [LBL_W-1:0]  branch_addr_o;
    logic [1:0]        const_o;
    logic [REG_W-1:0]  rd_o;
    logic [REG_W-1:0]  rs1_o;
    logic [REG_W-1:0]  rs2_o;
    logic [DATA_W-1:0] alu_out_o;
    logic              overflow_o;
    logic              taken_o;
    logic              halted_o;

    modport master (
        input  instr_i, rs1_data_i, rs2_data_i, cond_i,
        output pc_o, mem_read_o, mem_write_o, label_read_o, label_write_o,
               reg_write_o, halt_o, alu_op_o, branch_addr_o, const_o,
               rd_o, rs1_o, rs2_o, alu_out_o, overflow_o, taken_o, halted_o
    );

    modport slave (
        output instr_i, rs1_data_i, rs2_data_i, cond_i,
        input  pc_o, mem_read_o, mem_write_o, label_read_o, label_write_o,
               reg_write_o, halt_o, alu_op_o, branch_addr_o, const_o,
               rd_o, rs1_o, rs2_o, alu_out_o, overflow_o, taken_o, halted_o
    );

endinterface

// File: rtl/proc_alu.sv
// Combinational ALU. Also forwards the address/label operand for
// memory and branch opcodes so the core has a single result path.
module proc_alu
    import proc_pkg::*;
(
    input  opcode_t           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [1:0]        cnst,
    output logic [DATA_W-1:0] result,
    output logic              overflow
);

    logic [2:0]        k;
    logic [DATA_W:0]   add_w;
    logic [DATA_W:0]   sub_w;
    logic [DATA_W:0]   addi_w;
    logic [DATA_W+3:0] shl_w;

    // Shift distance is const+1, so 1..4; a 12-bit shift keeps every
    // shifted-out bit visible for the overflow flag.
    always_comb begin
        k      = {1'b0, cnst} + 3'd1;
        add_w  = {1'b0, a} + {1'b0, b};
        sub_w  = {1'b0, a} - {1'b0, b};
        addi_w = {1'b0, a} + {{(DATA_W-1){1'b0}}, cnst};
        shl_w  = {4'b0000, a} << k;
    end

    // Result and carry/borrow selection per opcode.
    always_comb begin
        result   = '0;
        overflow = 1'b0;
        case (op)
            OP_ADD:  begin result = add_w[DATA_W-1:0];  overflow = add_w[DATA_W];  end
            OP_SUB:  begin result = sub_w[DATA_W-1:0];  overflow = sub_w[DATA_W];  end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SHL:  begin result = shl_w[DATA_W-1:0];  overflow = |shl_w[DATA_W+3:DATA_W]; end
            OP_SHR:  result = a >> k;
            OP_ADDI: begin result = addi_w[DATA_W-1:0]; overflow = addi_w[DATA_W]; end
            OP_LD,
            OP_ST:   result = b;
            OP_SLT:  result = {{(DATA_W-1){1'b0}}, (a < b)};
            OP_BR,
            OP_BC:   result = a;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/proc_core.sv
// Single-cycle 8-bit core: decode, ALU instance and program counter.
// While start_n is low the PC output follows start_addr directly; the
// run flag then selects the registered PC once the first edge has
// executed the instruction at start_addr.
module proc_core
    import proc_pkg::*;
(
    input  logic            f_clk,
    input  logic            start_n,
    input  logic [PC_W-1:0] start_addr,
    proc_if.master          bus
);

    opcode_t           op;
    ctrl_t             ctrl;
    logic [DATA_W-1:0] alu_out;
    logic              alu_ovf;
    logic              taken;

    logic              run_q;
    logic [PC_W-1:0]   pc_q;
    logic              halted_q;
    logic [PC_W-1:0]   cur_pc;
    logic [PC_W-1:0]   next_pc;

    assign op = opcode_t'(bus.instr_i[7:4]);

    // Control decode; anything not listed for an opcode stays 0.
    always_comb begin
        ctrl = '0;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
            OP_SHL, OP_SHR, OP_ADDI, OP_SLT:
                     ctrl.reg_write = 1'b1;
            OP_LD:   begin ctrl.mem_read = 1'b1; ctrl.reg_write = 1'b1; end
            OP_ST:   ctrl.mem_write = 1'b1;
            OP_BR,
            OP_BC:   ctrl.label_read = 1'b1;
            OP_LBL:  begin ctrl.label_write = 1'b1; ctrl.reg_write = 1'b1; end
            OP_HALT: ctrl.halt = 1'b1;
            default: ctrl = '0;
        endcase
    end

    proc_alu u_alu (
        .op       (op),
        .a        (bus.rs1_data_i),
        .b        (bus.rs2_data_i),
        .cnst     (bus.instr_i[1:0]),
        .result   (alu_out),
        .overflow (alu_ovf)
    );

    // Branch resolution: BR always, BC on the stored condition bit.
    always_comb begin
        taken = (op == OP_BR) || ((op == OP_BC) && bus.cond_i);
    end

    // Current PC is start_addr until the first post-reset edge.
    always_comb begin
        cur_pc = run_q ? pc_q : start_addr;
    end

    // Next PC by priority: hold on halt, branch target, then increment.
    always_comb begin
        next_pc = cur_pc + PC_W'(1);
        if (halted_q || ctrl.halt)
            next_pc = cur_pc;
        else if (taken)
            next_pc = alu_out;
    end

    // PC, run flag and sticky halt register.
    always_ff @(posedge f_clk or negedge start_n) begin
        if (!start_n) begin
            run_q    <= 1'b0;
            pc_q     <= '0;
            halted_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
            pc_q  <= next_pc;
            if (ctrl.halt)
                halted_q <= 1'b1;
        end
    end

    assign bus.pc_o          = cur_pc;
    assign bus.mem_read_o    = ctrl.mem_read;
    assign bus.mem_write_o   = ctrl.mem_write;
    assign bus.label_read_o  = ctrl.label_read;
    assign bus.label_write_o = ctrl.label_write;
    assign bus.reg_write_o   = ctrl.reg_write;
    assign bus.halt_o        = ctrl.halt;
    assign bus.alu_op_o      = bus.instr_i[7:4];
    assign bus.branch_addr_o = bus.instr_i[3:0];
    assign bus.const_o       = bus.instr_i[1:0];
    assign bus.rd_o          = {1'b0, bus.instr_i[3:2]};
    assign bus.rs1_o         = {1'b0, bus.instr_i[3:2]};
    assign bus.rs2_o         = {1'b0, bus.instr_i[1:0]};
    assign bus.alu_out_o     = alu_out;
    assign bus.overflow_o    = alu_ovf;
    assign bus.taken_o       = taken;
    assign bus.halted_o      = halted_q;

endmodule

// File: tb/tb_proc_core.sv
// Bench for proc_core: directed scenarios plus a randomized instruction
// stream, all checked against an arithmetic model of the instruction set.
module tb_proc_core;

    logic       f_clk;
    logic       start_n;
    logic [7:0] start_addr;

    proc_if bus ();

    proc_core dut (
        .f_clk      (f_clk),
        .start_n    (start_n),
        .start_addr (start_addr),
        .bus        (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int m_pc    = 0;
    int m_halted = 0;

    always #5 f_clk = ~f_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Instruction-set model: opcode is the high nibble, const the low two bits.
    task automatic model(input int ins, input int a, input int b, input int cond,
                         output int res, output int ov, output int tk,
                         output int mr, output int mw, output int lr,
                         output int lw, output int rw, output int hl);
        int op, c, s, p;
        op = ins / 16;
        c  = ins % 4;
        p  = 1 << (c + 1);
        res = 0; ov = 0;
        case (op)
            0:  begin s = a + b;  res = s % 256; ov = (s > 255); end
            1:  begin res = (a - b + 256) % 256; ov = (a < b); end
            2:  res = a & b;
            3:  res = a | b;
            4:  res = a ^ b;
            5:  begin s = a * p; res = s % 256; ov = (s >= 256); end
            6:  res = a / p;
            7:  begin s = a + c;  res = s % 256; ov = (s > 255); end
            8, 9:   res = b;
            10: res = (a < b) ? 1 : 0;
            11, 12: res = a;
            default: res = 0;
        endcase
        tk = (op == 11) || (op == 12 && cond != 0);
        mr = (op == 8);
        mw = (op == 9);
        lr = (op == 11 || op == 12);
        lw = (op == 13);
        rw = (op <= 8 || op == 10 || op == 13);
        hl = (op == 15);
    endtask

    // Called at a negedge: drive one instruction, check decode, clock it,
    // check PC/halt state, return at the following negedge.
    task automatic step(input logic [7:0] ins, input logic [7:0] a,
                        input logic [7:0] b, input logic cond);
        int res, ov, tk, mr, mw, lr, lw, rw, hl;
        bus.instr_i    = ins;
        bus.rs1_data_i = a;
        bus.rs2_data_i = b;
        bus.cond_i     = cond;
        #1;
        model(int'(ins), int'(a), int'(b), int'(cond), res, ov, tk, mr, mw, lr, lw, rw, hl);
        chk("pc_pre",   bus.pc_o,          m_pc);
        chk("alu_op",   bus.alu_op_o,      ins / 16);
        chk("br_addr",  bus.branch_addr_o, ins % 16);
        chk("const",    bus.const_o,       ins % 4);
        chk("rd",       bus.rd_o,          (ins / 4) % 4);
        chk("rs1",      bus.rs1_o,         (ins / 4) % 4);
        chk("rs2",      bus.rs2_o,         ins % 4);
        chk("alu_out",  bus.alu_out_o,     res);
        chk("overflow", bus.overflow_o,    ov);
        chk("taken",    bus.taken_o,       tk);
        chk("ctl",      {bus.mem_read_o, bus.mem_write_o, bus.label_read_o,
                         bus.label_write_o, bus.reg_write_o, bus.halt_o},
                        {mr[0], mw[0], lr[0], lw[0], rw[0], hl[0]});
        if (m_halted == 0 && hl == 0)
            m_pc = (tk != 0) ? res : (m_pc + 1) % 256;
        if (hl != 0) m_halted = 1;
        @(posedge f_clk);
        #1;
        chk("pc_post",  bus.pc_o,     m_pc);
        chk("halted",   bus.halted_o, m_halted);
        @(negedge f_clk);
    endtask

    // Called at a negedge: assert reset off-edge, check PC tracking, release.
    task automatic do_reset(input logic [7:0] addr);
        logic [7:0] alt;
        alt = addr ^ 8'h5A;
        #2;
        start_n    = 1'b0;
        start_addr = addr;
        #1;
        chk("rst_pc",     bus.pc_o,     addr);
        chk("rst_halted", bus.halted_o, 0);
        start_addr = alt;
        #1;
        chk("rst_track",  bus.pc_o,     alt);
        start_addr = addr;
        @(posedge f_clk);
        #1;
        chk("rst_hold",   bus.pc_o,     addr);
        m_pc = addr;
        m_halted = 0;
        @(negedge f_clk);
        start_n = 1'b1;
    endtask

    initial begin
        logic [7:0] ins;
        f_clk = 1'b0;
        start_n = 1'b0;
        start_addr = 8'h00;
        bus.instr_i = 8'hE0;
        bus.rs1_data_i = 8'h00;
        bus.rs2_data_i = 8'h00;
        bus.cond_i = 1'b0;
        @(negedge f_clk);

        // Reset release and sequential fetch from start_addr.
        do_reset(8'h10);
        step(8'hE0, 8'h00, 8'h00, 1'b0);
        chk("seq_11", bus.pc_o, 8'h11);
        step(8'hE0, 8'h00, 8'h00, 1'b0);
        chk("seq_12", bus.pc_o, 8'h12);

        // ADD carry and SUB borrow.
        step(8'h00, 8'hF0, 8'h20, 1'b0);
        chk("add_res", bus.alu_out_o, 8'h10);
        chk("add_ovf", bus.overflow_o, 1);
        chk("add_rw",  bus.reg_write_o, 1);
        step(8'h10, 8'h05, 8'h07, 1'b0);
        chk("sub_res", bus.alu_out_o, 8'hFE);
        chk("sub_ovf", bus.overflow_o, 1);

        // Branches from PC 0x05.
        do_reset(8'h05);
        step(8'hB0, 8'h40, 8'h00, 1'b0);
        chk("br_pc", bus.pc_o, 8'h40);
        do_reset(8'h05);
        step(8'hC0, 8'h40, 8'h00, 1'b0);
        chk("bc_pc", bus.pc_o, 8'h06);

        // HALT freezes the PC even with branches pending, reset clears it.
        do_reset(8'h07);
        step(8'hF0, 8'h00, 8'h00, 1'b0);
        chk("halt_set", bus.halted_o, 1);
        for (int i = 0; i < 10; i++)
            step(8'hB0 | 8'(i % 2), 8'h99, 8'h11, 1'b1);
        chk("halt_pc", bus.pc_o, 8'h07);
        do_reset(8'h22);
        chk("halt_clr", bus.halted_o, 0);

        // PC wrap and SHL overflow.
        do_reset(8'hFF);
        step(8'hE0, 8'h00, 8'h00, 1'b0);
        chk("wrap_pc", bus.pc_o, 8'h00);
        step(8'h50, 8'h81, 8'h00, 1'b0);
        chk("shl_res", bus.alu_out_o, 8'h02);
        chk("shl_ovf", bus.overflow_o, 1);

        // Memory / label control sets.
        step(8'h80, 8'h12, 8'h34, 1'b0);
        chk("ld_ctl",  {bus.mem_read_o, bus.mem_write_o, bus.label_write_o, bus.reg_write_o}, 4'b1001);
        step(8'h90, 8'h12, 8'h34, 1'b0);
        chk("st_ctl",  {bus.mem_read_o, bus.mem_write_o, bus.label_write_o, bus.reg_write_o}, 4'b0100);
        step(8'hD0, 8'h12, 8'h34, 1'b0);
        chk("lbl_ctl", {bus.mem_read_o, bus.mem_write_o, bus.label_write_o, bus.reg_write_o}, 4'b0011);

        // Random instruction stream with occasional HALT and reset.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 39) == 0)
                do_reset(8'($urandom));
            if ($urandom_range(0, 49) == 0)
                ins = {4'hF, 4'($urandom)};
            else
                ins = {4'($urandom_range(0, 14)), 4'($urandom)};
            step(ins, 8'($urandom), 8'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
